// File: rtl/cnn_window_gen_pkg.sv
// Shared sizing constants and helpers for the CNN sliding-window generator.
// Kernel size is one-hot: bit1 selects 2, bit2 selects 3.
package cnn_window_gen_pkg;

  localparam int KERNEL_SIZE   = 3;
  localparam int IMG_DIM_WIDTH = 16;
  localparam int WINDOW_SIZE   = 9;

  // Largest multiple of the kernel size not exceeding dim (integer division).
  function automatic logic [IMG_DIM_WIDTH-1:0] blk_limit(input logic [IMG_DIM_WIDTH-1:0] dim,
                                                         input logic k3);
    if (k3) return (dim / IMG_DIM_WIDTH'(3)) * IMG_DIM_WIDTH'(3);
    return {dim[IMG_DIM_WIDTH-1:1], 1'b0};
  endfunction

endpackage

// File: rtl/cnn_window_gen_line_buffer.sv
// One image row of storage: simple dual-port RAM, registered read (1-cycle latency).
// Contents are never reset.
module CNNLineBuffer
  import cnn_window_gen_pkg::*;
#(
  parameter int MAX_WIDTH = 64,
  parameter int DW        = 32,
  parameter int AW        = 6
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem_reg [MAX_WIDTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem_reg[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem_reg[rd_addr];
  end

endmodule

// File: rtl/cnn_window_gen.sv
// Non-overlapping kh x kw window extractor over a raster pixel stream.
// Upper block rows come from line buffers, the current row from shift registers.
module cnn_window_gen
  import cnn_window_gen_pkg::*;
#(
  parameter int MAX_WIDTH = 64,
  parameter int DW        = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        conf_refresh,
  input  logic [KERNEL_SIZE-1:0]      kernel_height,
  input  logic [KERNEL_SIZE-1:0]      kernel_width,
  input  logic [IMG_DIM_WIDTH-1:0]    img_width,
  input  logic [IMG_DIM_WIDTH-1:0]    img_height,
  input  logic                        in_valid,
  input  logic [DW-1:0]               in_data,
  output logic                        in_ready,
  output logic                        window_valid,
  output logic [WINDOW_SIZE*DW-1:0]   window,
  input  logic                        window_stall,
  output logic                        frame_done
);

  localparam int AW = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;

  logic                     kh3_reg, kw3_reg;
  logic [IMG_DIM_WIDTH-1:0] w_reg, h_reg, w_lim_reg, h_lim_reg;
  logic [IMG_DIM_WIDTH-1:0] col_reg, row_reg, col_next, row_next;
  logic [1:0]               cmod_reg, rmod_reg, cmod_next, rmod_next;
  logic [1:0]               kh_m1, kw_m1;
  logic                     accept, block_done, frame_end, rd_en;
  logic                     window_valid_reg, frame_done_reg;
  logic [DW-1:0]            rd_data    [2];
  logic [DW-1:0]            cur_sr     [2];
  logic [DW-1:0]            up_sr      [2][2];
  logic [DW-1:0]            src        [3][3];
  logic [DW-1:0]            win_next   [WINDOW_SIZE];
  logic [DW-1:0]            window_reg [WINDOW_SIZE];

  assign in_ready     = ~window_stall;
  assign accept       = in_valid & ~window_stall & ~conf_refresh;
  assign kh_m1        = kh3_reg ? 2'd2 : 2'd1;
  assign kw_m1        = kw3_reg ? 2'd2 : 2'd1;
  assign window_valid = window_valid_reg;
  assign frame_done   = frame_done_reg;

  assign block_done = accept && (cmod_reg == kw_m1) && (rmod_reg == kh_m1) &&
                      (col_reg < w_lim_reg) && (row_reg < h_lim_reg);
  assign frame_end  = accept && (col_reg == w_reg - IMG_DIM_WIDTH'(1)) &&
                      (row_reg == h_reg - IMG_DIM_WIDTH'(1));

  always_comb begin
    col_next  = col_reg;
    row_next  = row_reg;
    cmod_next = cmod_reg;
    rmod_next = rmod_reg;
    if (conf_refresh) begin
      col_next  = '0;
      row_next  = '0;
      cmod_next = '0;
      rmod_next = '0;
    end else if (accept) begin
      if (col_reg == w_reg - IMG_DIM_WIDTH'(1)) begin
        col_next  = '0;
        cmod_next = '0;
        if (row_reg == h_reg - IMG_DIM_WIDTH'(1)) begin
          row_next  = '0;
          rmod_next = '0;
        end else begin
          row_next  = row_reg + IMG_DIM_WIDTH'(1);
          rmod_next = (rmod_reg == kh_m1) ? 2'd0 : rmod_reg + 2'd1;
        end
      end else begin
        col_next  = col_reg + IMG_DIM_WIDTH'(1);
        cmod_next = (cmod_reg == kw_m1) ? 2'd0 : cmod_reg + 2'd1;
      end
    end
  end

  // Reading at the next column makes rd_data line up with the pixel offered this cycle.
  assign rd_en = (rmod_next == kh_m1);

  for (genvar gi = 0; gi < 2; gi++) begin : g_lb
    logic wr_en;
    assign wr_en = accept && (rmod_reg == 2'(gi)) && (rmod_reg != kh_m1);
    CNNLineBuffer #(.MAX_WIDTH(MAX_WIDTH), .DW(DW), .AW(AW)) u_lb (
      .clk     (clk),
      .wr_en   (wr_en),
      .wr_addr (col_reg[AW-1:0]),
      .wr_data (in_data),
      .rd_en   (rd_en),
      .rd_addr (col_next[AW-1:0]),
      .rd_data (rd_data[gi])
    );
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      cur_sr[0] <= in_data;
      cur_sr[1] <= cur_sr[0];
      for (int b = 0; b < 2; b++) begin
        up_sr[b][0] <= rd_data[b];
        up_sr[b][1] <= up_sr[b][0];
      end
    end
  end

  // src[r][d]: block row r, d pixels left of the current column.
  always_comb begin
    src[0][0] = rd_data[0];
    src[0][1] = up_sr[0][0];
    src[0][2] = up_sr[0][1];
    src[1][0] = kh3_reg ? rd_data[1]  : in_data;
    src[1][1] = kh3_reg ? up_sr[1][0] : cur_sr[0];
    src[1][2] = kh3_reg ? up_sr[1][1] : cur_sr[1];
    src[2][0] = in_data;
    src[2][1] = cur_sr[0];
    src[2][2] = cur_sr[1];
  end

  always_comb begin
    for (int i = 0; i < WINDOW_SIZE; i++) win_next[i] = '0;
    if (block_done) begin
      if (kw3_reg) begin
        for (int r = 0; r < 3; r++)
          for (int c = 0; c < 3; c++)
            if (r < 2 || kh3_reg) win_next[r*3+c] = src[r][2-c];
      end else begin
        for (int r = 0; r < 3; r++)
          for (int c = 0; c < 2; c++)
            if (r < 2 || kh3_reg) win_next[r*2+c] = src[r][1-c];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      kh3_reg          <= 1'b0;
      kw3_reg          <= 1'b0;
      w_reg            <= '0;
      h_reg            <= '0;
      w_lim_reg        <= '0;
      h_lim_reg        <= '0;
      col_reg          <= '0;
      row_reg          <= '0;
      cmod_reg         <= '0;
      rmod_reg         <= '0;
      window_valid_reg <= 1'b0;
      frame_done_reg   <= 1'b0;
      for (int i = 0; i < WINDOW_SIZE; i++) window_reg[i] <= '0;
    end else if (conf_refresh) begin
      kh3_reg          <= (kernel_height == KERNEL_SIZE'(4));
      kw3_reg          <= (kernel_width == KERNEL_SIZE'(4));
      w_reg            <= img_width;
      h_reg            <= img_height;
      w_lim_reg        <= blk_limit(img_width, kernel_width == KERNEL_SIZE'(4));
      h_lim_reg        <= blk_limit(img_height, kernel_height == KERNEL_SIZE'(4));
      col_reg          <= '0;
      row_reg          <= '0;
      cmod_reg         <= '0;
      rmod_reg         <= '0;
      window_valid_reg <= 1'b0;
      frame_done_reg   <= 1'b0;
      for (int i = 0; i < WINDOW_SIZE; i++) window_reg[i] <= '0;
    end else if (!window_stall) begin
      col_reg          <= col_next;
      row_reg          <= row_next;
      cmod_reg         <= cmod_next;
      rmod_reg         <= rmod_next;
      window_valid_reg <= block_done;
      frame_done_reg   <= frame_end;
      for (int i = 0; i < WINDOW_SIZE; i++) window_reg[i] <= win_next[i];
    end
  end

  for (genvar gi = 0; gi < WINDOW_SIZE; gi++) begin : g_win
    assign window[gi*DW +: DW] = window_reg[gi];
  end

endmodule

// File: doc/cnn_window_gen.md
CNN_WINDOW_GEN -- requirements
Module: cnn_window_gen

Interface
REQ-001 SHALL have parameter MAX_WIDTH, default 64: maximum image row length in pixels.
REQ-002 SHALL have parameter DW, default 32: pixel width in bits.
REQ-003 SHALL have port clk, input, 1: the single clock for all state.
REQ-004 SHALL have port rst, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port conf_refresh, input, 1: latches the configuration and aborts any frame in progress.
REQ-006 SHALL have ports kernel_height and kernel_width, input, `KERNEL_SIZE each: one-hot kernel size; bit1 = 2, bit2 = 3.
REQ-007 SHALL have port img_width, input, `IMG_DIM_WIDTH: row length W, valid range 2..MAX_WIDTH.
REQ-008 SHALL have port img_height, input, `IMG_DIM_WIDTH: row count H.
REQ-009 SHALL have port in_valid, input, 1: pixel offered, raster order.
REQ-010 SHALL have port in_data, input, DW: pixel value.
REQ-011 SHALL have port in_ready, output, 1: pixel accepted when in_valid & in_ready.
REQ-012 SHALL have port window_valid, output, 1: window present; drives the pool stage.
REQ-013 SHALL have port window, output, `WINDOW_SIZE x DW: window entries.
REQ-014 SHALL have port window_stall, input, 1: downstream stall.
REQ-015 SHALL have port frame_done, output, 1: one-cycle pulse after the last pixel of a frame is accepted.

Function
REQ-016 SHALL use kh, kw in {2,3} from the latched one-hot config; stride equals kernel size, so windows do not overlap.
REQ-017 SHALL drive in_ready = ~window_stall combinationally.
REQ-018 SHALL hold all state, including window, window_valid and counters, unchanged while window_stall = 1.
REQ-019 SHALL track col (0..W-1) and row (0..H-1) counters that advance only on an accepted pixel; col wraps to 0 at W-1 and increments row.
REQ-020 SHALL write each accepted pixel with row%kh < kh-1 into line buffer (row%kh) at address col.
REQ-021 SHALL hold the last kw-1 pixels of the current row in shift registers.
REQ-022 SHALL treat a block as complete when an accepted pixel has col%kw = kw-1, row%kh = kh-1, col < (W/kw)*kw and row < (H/kh)*kh, using integer division.
REQ-023 SHALL, on a completed block, register window_valid = 1 for exactly one non-stalled cycle in the next clock; latency is 1 cycle.
REQ-024 SHALL otherwise register window_valid = 0 on every non-stalled cycle.
REQ-025 SHALL order the window as window[r*kw + c], with r = 0 the top row and c = 0 the left column.
REQ-026 SHALL drive entries with index >= kh*kw to 0.
REQ-027 SHALL drive the window to all zeros whenever window_valid = 0.
REQ-028 SHALL drop trailing partial columns (W%kw) and trailing partial rows (H%kh) silently while still counting them.
REQ-029 SHALL, on acceptance of pixel (H-1, W-1), pulse frame_done for one cycle and reset row and col to 0, ready for the next frame.
REQ-030 SHALL, on conf_refresh, take effect at the next clock: latch config, clear counters, window_valid and frame_done, and drop any pixel offered in that same cycle.
REQ-031 SHALL give conf_refresh priority over window_stall.

Reset
REQ-032 SHALL, while rst = 0, asynchronously clear counters, window_valid, window, frame_done and latched config, with kh = kw = 2 and W = H = 0.
REQ-033 SHALL leave line buffer contents undefined after reset and SHALL never read them before they are written in the current frame.
REQ-034 SHALL, on reset mid-frame, discard the partial frame; the first pixel after release is (0,0).

Structure
REQ-035 SHALL take `WINDOW_SIZE, `KERNEL_SIZE and `IMG_DIM_WIDTH from the shared CNNConfig.vh.
REQ-036 SHALL implement each line buffer as sub-module CNNLineBuffer, a MAX_WIDTH x DW RAM with one write and one read port and 1-cycle read latency; two instances.

Verification
REQ-037 SHALL cover 2x2, W = 4, H = 2, pixels 1..8 with no stall -> exactly two windows, {1,2,5,6} then {3,4,7,8}, entries 4..8 = 0, frame_done one cycle after pixel 8.
REQ-038 SHALL cover 3x3, W = 7, H = 3, pixels 1..21 -> two windows, {1,2,3,8,9,10,15,16,17} then {4,5,6,11,12,13,18,19,20}; column 6 dropped.
REQ-039 SHALL cover 2x2, W = 4, H = 2 with window_stall held high 3 cycles while window_valid = 1 -> in_ready = 0 for those cycles, window held constant, delivered once after release, no pixel lost.
REQ-040 SHALL cover conf_refresh asserted after 5 pixels of a 2x2 frame, then a fresh 3x3 frame -> no window from the aborted data, correct 3x3 windows from the new frame.
REQ-041 SHALL cover rst pulsed low mid-frame -> window_valid and frame_done drop immediately, next frame windows correct.
REQ-042 SHALL cover two back-to-back 2x2 frames, W = 4, H = 4, with random in_valid gaps -> 4 windows per frame in raster block order, two frame_done pulses.
